// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between
// two requesters, one transaction at a time.
module data_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t      state;
  logic        owner;
  logic        we_q;
  logic        last_grant;
  logic [CW-1:0] cnt;

  logic              any;
  logic              pick;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the port that did not win last time gets the slot.
  always_comb begin
    any  = r0_req | r1_req;
    pick = (r0_req & r1_req) ? ~last_grant : r1_req;
    sel_we    = pick ? r1_we    : r0_we;
    sel_addr  = pick ? r1_addr  : r0_addr;
    sel_wdata = pick ? r1_wdata : r0_wdata;
  end

  // Grant is decided in the IDLE cycle itself; held low during reset.
  assign r0_gnt = ~rst & (state == IDLE) & any & ~pick;
  assign r1_gnt = ~rst & (state == IDLE) & any & pick;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            owner      <= pick;
            we_q       <= sel_we;
            last_grant <= pick;
            cnt        <= CW'(MEM_LAT - 1);
            mem_read   <= ~sel_we;
            mem_write  <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner) r1_rdata <= mem_rdata;
              else       r0_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r0_ack    <= ~owner;
            r1_ack    <= owner;
            state     <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
